// File: rtl/vr_stream_arbiter_if.sv
// Valid-ready bundle between N_SRC requesters and one shared output stream.
// The arbiter uses the master modport; the requester/sink side uses slave.
interface vr_stream_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32
);
    logic [N_SRC*DATA_W-1:0] in_data;
    logic [N_SRC-1:0]        in_last;
    logic [N_SRC-1:0]        in_valid;
    logic [N_SRC-1:0]        in_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_valid
    );

    modport slave (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_valid
    );
endinterface

// File: rtl/vr_stream_arbiter.sv
// Packet-aware round-robin arbiter: a grant is held from first beat to last beat.
// Optional 2-entry output skid slice enabled by defining VR_ARB_OUT_REG_EN.
module vr_stream_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W  = $clog2(N_SRC)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic                 sync_rst,
    vr_stream_arbiter_if.master  bus,
    output logic [SRC_W-1:0]     out_src,
    output logic                 busy,
    output logic [15:0]          pkt_count
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q;
    logic [SRC_W-1:0]   grant_q;
    logic [SRC_W-1:0]   rr_ptr_q;
    logic [15:0]        pkt_cnt_q;

    logic               locked;
    logic               core_valid;
    logic               core_ready;
    logic               core_last;
    logic [DATA_W-1:0]  core_data;
    logic               core_hs;
    logic [SRC_W-1:0]   next_rr;
    logic               any_req;
    logic [SRC_W-1:0]   pick;
    int                 idx;

    assign locked     = (state_q == LOCKED);
    assign core_valid = locked && en && bus.in_valid[grant_q];
    assign core_data  = bus.in_data[int'(grant_q)*DATA_W +: DATA_W];
    assign core_last  = bus.in_last[grant_q];
    assign core_hs    = core_valid && core_ready;
    // Explicit wrap so non-power-of-two N_SRC never points past the last source.
    assign next_rr    = (grant_q == SRC_W'(N_SRC-1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        any_req = 1'b0;
        pick    = rr_ptr_q;
        idx     = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!any_req && bus.in_valid[SRC_W'(idx)]) begin
                any_req = 1'b1;
                pick    = SRC_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else if (sync_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && any_req) begin
                        grant_q <= pick;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (core_hs && core_last) begin
                        state_q   <= IDLE;
                        rr_ptr_q  <= next_rr;
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = '0;
        if (locked && en) bus.in_ready[grant_q] = core_ready;
    end

    assign out_src   = grant_q;
    assign busy      = locked;
    assign pkt_count = pkt_cnt_q;

`ifdef VR_ARB_OUT_REG_EN
    logic [DATA_W:0] sk_mem_q [2];
    logic [1:0]      sk_cnt_q;
    logic [1:0]      sk_cnt_d;
    logic            sk_rd_q;
    logic            sk_wr_q;
    logic            sk_push;
    logic            sk_pop;

    // Ready depends only on slice occupancy, breaking the out_ready -> in_ready path.
    assign core_ready    = (sk_cnt_q != 2'd2);
    assign bus.out_valid = en && (sk_cnt_q != 2'd0);
    assign bus.out_data  = sk_mem_q[sk_rd_q][DATA_W-1:0];
    assign bus.out_last  = sk_mem_q[sk_rd_q][DATA_W];
    assign sk_push       = core_hs;
    assign sk_pop        = bus.out_valid && bus.out_ready;

    always_comb begin
        sk_cnt_d = sk_cnt_q;
        case ({sk_push, sk_pop})
            2'b10:   sk_cnt_d = sk_cnt_q + 2'd1;
            2'b01:   sk_cnt_d = sk_cnt_q - 2'd1;
            default: sk_cnt_d = sk_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sk_mem_q[0] <= '0;
            sk_mem_q[1] <= '0;
            sk_cnt_q    <= '0;
            sk_rd_q     <= 1'b0;
            sk_wr_q     <= 1'b0;
        end else if (sync_rst) begin
            sk_mem_q[0] <= '0;
            sk_mem_q[1] <= '0;
            sk_cnt_q    <= '0;
            sk_rd_q     <= 1'b0;
            sk_wr_q     <= 1'b0;
        end else begin
            if (sk_push) begin
                sk_mem_q[sk_wr_q] <= {core_last, core_data};
                sk_wr_q           <= ~sk_wr_q;
            end
            if (sk_pop) sk_rd_q <= ~sk_rd_q;
            sk_cnt_q <= sk_cnt_d;
        end
    end
`else
    assign core_ready    = bus.out_ready;
    assign bus.out_valid = core_valid;
    assign bus.out_data  = core_data;
    assign bus.out_last  = core_last;
`endif

endmodule

// File: tb/tb_vr_stream_arbiter.sv
// Directed bench for vr_stream_arbiter: per-source beat queues drive the inputs,
// and a negedge monitor pops an expected-beat scoreboard on every output handshake.
module tb_vr_stream_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
        logic [1:0]   s;
    } beat_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic        sync_rst;
    logic [1:0]  out_src;
    logic        busy;
    logic [15:0] pkt_count;

    int n_pass  = 0;
    int n_total = 0;

    beat_t srcq [N][$];
    beat_t expq [$];

    vr_stream_arbiter_if #(.N_SRC(N), .DATA_W(W)) bus ();

    vr_stream_arbiter #(.N_SRC(N), .DATA_W(W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .sync_rst  (sync_rst),
        .bus       (bus.master),
        .out_src   (out_src),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input int s, input logic [W-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        b.s = 2'(s);
        srcq[s].push_back(b);
        expq.push_back(b);
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                bus.in_valid[i]          = 1'b1;
                bus.in_data[i*W +: W]    = srcq[i][0].d;
                bus.in_last[i]           = srcq[i][0].l;
            end else begin
                bus.in_valid[i]          = 1'b0;
                bus.in_data[i*W +: W]    = '0;
                bus.in_last[i]           = 1'b0;
            end
        end
    endtask

    // One clock: pop beats that handshake at this edge, apply controls, stop at the negedge.
    task automatic step(input logic o, input logic e, input logic sr, input logic fl);
        logic [N-1:0] hsv;
        hsv = bus.in_valid & bus.in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (hsv[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (fl) begin
            for (int i = 0; i < N; i++) srcq[i].delete();
            expq.delete();
        end
        bus.out_ready = o;
        en            = e;
        sync_rst      = sr;
        refresh();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (nrst && bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                check("sb_unexpected_beat", 32'(bus.out_data), 32'hDEAD_BEEF);
            end else begin
                b = expq.pop_front();
                check("sb_data", bus.out_data, b.d);
                check("sb_last", 32'(bus.out_last), 32'(b.l));
                check("sb_src",  32'(out_src), 32'(b.s));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int cnt1;
        bit pushed;
        logic [15:0] pc0;

        en = 1'b1;
        sync_rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = '0;
        bus.in_last = '0;
        bus.in_data = '0;
        do_reset();

        check("rst_in_ready",  32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_src",   32'(out_src), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_pkt_count", 32'(pkt_count), 0);

        // Single 3-beat packet on source 2.
        push(2, 32'hA0, 1'b0);
        push(2, 32'hA1, 1'b0);
        push(2, 32'hA2, 1'b1);
        step(1, 1, 0, 0);
        check("t1_latency_valid", 32'(bus.out_valid), 0);
        check("t1_idle_ready",    32'(bus.in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0);
            check("t1_out_valid", 32'(bus.out_valid), 1);
            check("t1_out_src",   32'(out_src), 2);
        end
        step(1, 1, 0, 0);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_pkt_count", 32'(pkt_count), 1);

        // Pointer now at 3: source 3 must win over source 0.
        push(3, 32'h31, 1'b1);
        push(0, 32'h30, 1'b1);
        repeat (5) step(1, 1, 0, 0);
        check("t1b_pkt_count", 32'(pkt_count), 3);

        do_reset();

        // All sources busy with 1-beat packets: 0,1,2,3,0 with bubbles.
        push(0, 32'hB0, 1'b1);
        push(1, 32'hB1, 1'b1);
        push(2, 32'hB2, 1'b1);
        push(3, 32'hB3, 1'b1);
        push(0, 32'hB4, 1'b1);
        step(1, 1, 0, 0);
        check("t2_first_bubble", 32'(bus.out_valid), 0);
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 0, 0);
            check("t2_valid_pattern", 32'(bus.out_valid), 32'((k % 2) == 0));
        end
        check("t2_pkt_count", 32'(pkt_count), 5);

        // Source 0 requests while source 1 is mid-packet: no pre-emption.
        push(1, 32'hC0, 1'b0);
        push(1, 32'hC1, 1'b0);
        push(1, 32'hC2, 1'b0);
        push(1, 32'hC3, 1'b1);
        cnt1 = 0;
        pushed = 0;
        for (int k = 0; k < 30 && !(pkt_count == 16'd7 && !busy); k++) begin
            step(1, 1, 0, 0);
            if (busy && out_src == 2'd1) check("t3_in_ready0", 32'(bus.in_ready[0]), 0);
            if (bus.in_valid[1] && bus.in_ready[1]) cnt1++;
            if (cnt1 == 2 && !pushed) begin
                push(0, 32'hD0, 1'b1);
                pushed = 1;
            end
        end
        check("t3_pkt_count", 32'(pkt_count), 7);

        // out_ready stall for 5 cycles on source 3.
        push(3, 32'hE0, 1'b0);
        push(3, 32'hE1, 1'b0);
        push(3, 32'hE2, 1'b0);
        push(3, 32'hE3, 1'b1);
        repeat (3) step(1, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0);
            check("t4_valid_held", 32'(bus.out_valid), 1);
            check("t4_data_stable", bus.out_data, 32'hE2);
            check("t4_in_ready", 32'(bus.in_ready), 0);
        end
        repeat (3) step(1, 1, 0, 0);
        check("t4_busy_end", 32'(busy), 0);
        check("t4_pkt_count", 32'(pkt_count), 8);

        // en low for 3 cycles mid-packet on source 1.
        push(1, 32'hF0, 1'b0);
        push(1, 32'hF1, 1'b0);
        push(1, 32'hF2, 1'b0);
        push(1, 32'hF3, 1'b1);
        repeat (3) step(1, 1, 0, 0);
        pc0 = pkt_count;
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0);
            check("t5_out_valid", 32'(bus.out_valid), 0);
            check("t5_in_ready",  32'(bus.in_ready), 0);
            check("t5_busy",      32'(busy), 1);
            check("t5_grant",     32'(out_src), 1);
        end
        repeat (3) step(1, 1, 0, 0);
        check("t5_pkt_once", 32'(pkt_count), 32'(pc0) + 1);

        // sync_rst mid-packet on source 3 (pointer at 2 before the pulse).
        push(3, 32'h60, 1'b0);
        push(3, 32'h61, 1'b0);
        push(3, 32'h62, 1'b0);
        push(3, 32'h63, 1'b1);
        repeat (3) step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 0, 1);
        check("t6_busy",      32'(busy), 0);
        check("t6_pkt_count", 32'(pkt_count), 0);
        check("t6_out_valid", 32'(bus.out_valid), 0);
        push(0, 32'h70, 1'b1);
        push(2, 32'h72, 1'b1);
        repeat (5) step(1, 1, 0, 0);
        check("t6_pkt_after", 32'(pkt_count), 2);

        check("sb_drained", 32'(expq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
